bram_tdp_asym_init: RTL and testbench
=====================================

Name: bram_tdp_asym_init

Overview:
- Parametrised true dual-port block RAM with independent widths on ports A and B (power-of-two ratio) and per-byte write enables.
- Configurable read latency and read-during-write mode.
- Reset-triggered zero-clear sweep with an init-done flag.
- Backing store for the pipeline's caches, TLBs and host-transplant buffers; one shared clock.

Parameters:
- ADDR_WIDTH_A, 10: port A address bits; depth A = 2^ADDR_WIDTH_A.
- DATA_WIDTH_A, 64: port A data bits.
- ADDR_WIDTH_B, 9: port B address bits.
- DATA_WIDTH_B, 128: port B data bits. Constraint: DATA_WIDTH_A*2^ADDR_WIDTH_A == DATA_WIDTH_B*2^ADDR_WIDTH_B.
- BYTE_WIDTH, 8: bits per write-enable lane; must divide min(DATA_WIDTH_A, DATA_WIDTH_B).
- READ_LATENCY, 1: 1 = array register only; 2 = extra output register.
- RDW_MODE, 0: 0 = write-first (new data on read port), 1 = read-first (old data).
- INIT_CLEAR, 1: 1 = zero array after reset; 0 = skip straight to READY.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- initDone  out  1  array usable; ports ignored while low.
- enA  in  1  port A access enable.
- weA  in  DATA_WIDTH_A/BYTE_WIDTH  port A byte write enables.
- addrA  in  ADDR_WIDTH_A  port A word address.
- diA  in  DATA_WIDTH_A  port A write data.
- doA  out  DATA_WIDTH_A  port A read data.
- validA  out  1  doA carries data for an accepted access.
- enB, weB, addrB, diB, doB, validB: same as port A with _B widths.
- collision  out  1  present only with BRAM_COLLISION_CHECK_EN.

Behaviour:
Array mapping
- Array is NARROW = min width words; RATIO = max/min width (power of two, checked at elaboration).
- Wide word W covers narrow words W*RATIO+k, k = 0..RATIO-1, placed at wide bits [k*NARROW +: NARROW] (little-endian).
- Byte lane j of a port covers that port's data bits [j*BYTE_WIDTH +: BYTE_WIDTH].

Reset and init FSM (states CLEAR, READY)
- rst high: outputs doA = doB = 0, validA = validB = 0, initDone = 0; state = CLEAR if INIT_CLEAR else READY.
- CLEAR: row counter sweeps wide rows 0..2^ADDR_WIDTH_wide-1, writing zero to one full wide row per cycle.
- CLEAR: enA/enB ignored, no user writes, valid stays 0.
- initDone rises the cycle after the last row write; state = READY.
- rst asserted mid-sweep restarts the counter at 0.
- INIT_CLEAR=0: initDone = 1 the cycle after rst deasserts; array contents undefined (X in simulation).

READY, per port (ports fully independent)
- Access accepted when en & initDone.
- Write: each byte lane with we bit set updates at the clock edge.
- Read on every accepted access, including writes.
- Read data: doX appears READ_LATENCY cycles after the accepting edge; validX pulses aligned with it.
- Not accepted: doX holds its last value; validX = 0.
- Write-first: doX returns stored data merged with the enabled written bytes.
- Read-first: doX returns pre-write contents.

Simultaneous access
- Both ports accepted, addressed regions overlap, at least one writing:
  - Both write the same byte: port B wins.
  - A reader on the other port receives pre-write contents for overlapping bytes.
- Non-overlapping simultaneous accesses are fully independent.

Address wrap
- Address width exactly spans depth; no out-of-range case exists.

Optional Feature:
BRAM_COLLISION_CHECK_EN
- Defined:
  - Adds the collision output.
  - collision is a sticky flag set the cycle after an overlapping access with any write; cleared only by rst.
  - Simulation also emits $error with both addresses.
- Undefined: no collision port, no detection logic; simultaneous-access behaviour unchanged.

Decomposition:
- Shared package bram_pkg holds:
  - RDW_WRITE_FIRST / RDW_READ_FIRST constants.
  - Init FSM state enum (CLEAR, READY).
  - Functions log2 and max/min (replacing ad hoc macros).
- One sub-module: bram_out_pipe.
  - Parametrised by width and READ_LATENCY.
  - Carries doX and validX through the optional second register.
  - Instantiated once per port.

Test Plan:
- Defaults, rst 1 cycle then release: initDone low for exactly 512 cycles, then high; read A addr 0..1023 all return 0; validA 1 cycle after each enA.
- Width/byte merge: B writes addr 5 = 0x0011..FF (128-bit pattern) with weB all ones; A reads addr 10 -> low 64 bits, addr 11 -> high 64 bits. Then A writes addr 10 with weA = 0x01, di = 0xAA; B reads addr 5 -> only byte 0 changed to 0xAA.
- RDW: RDW_MODE=0, A writes 0x1234 to addr 3 with enA held; doA = 0x1234 next cycle. Same stimulus with RDW_MODE=1 returns the prior value 0x0.
- READ_LATENCY=2: read issued at cycle t; doA/validA at t+2; back-to-back reads at t, t+1 arrive at t+2, t+3 in order.
- Collision with macro defined: A writes addr 8 = 0x1, B writes addr 4 (covers A 8..9) = all ones, same cycle; final A addr 8 reads ~0; collision = 1 next cycle and stays 1 until rst.
- Reset mid-sweep: assert rst at cycle 200 of CLEAR; initDone stays low for a further 512 cycles after release; no user write before initDone lands.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants, init FSM state type and elaboration helpers for the asymmetric TDP BRAM.
package bram_pkg;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;

  typedef enum logic [0:0] {CLEAR, READY} init_state_e;

  // Ceiling log2; log2(1) == 0.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned max_val(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned min_val(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/bram_tdp_asym_init_if.sv
// Dual-port access bundle for bram_tdp_asym_init; master drives requests, slave is the RAM.
interface bram_tdp_asym_init_if #(
  parameter int unsigned ADDR_WIDTH_A = 10,
  parameter int unsigned DATA_WIDTH_A = 64,
  parameter int unsigned ADDR_WIDTH_B = 9,
  parameter int unsigned DATA_WIDTH_B = 128,
  parameter int unsigned BYTE_WIDTH   = 8
);

  logic                               initDone;
  logic                               enA;
  logic [DATA_WIDTH_A/BYTE_WIDTH-1:0] weA;
  logic [ADDR_WIDTH_A-1:0]            addrA;
  logic [DATA_WIDTH_A-1:0]            diA;
  logic [DATA_WIDTH_A-1:0]            doA;
  logic                               validA;
  logic                               enB;
  logic [DATA_WIDTH_B/BYTE_WIDTH-1:0] weB;
  logic [ADDR_WIDTH_B-1:0]            addrB;
  logic [DATA_WIDTH_B-1:0]            diB;
  logic [DATA_WIDTH_B-1:0]            doB;
  logic                               validB;

  modport master (
    output enA, weA, addrA, diA, enB, weB, addrB, diB,
    input  initDone, doA, validA, doB, validB
  );

  modport slave (
    input  enA, weA, addrA, diA, enB, weB, addrB, diB,
    output initDone, doA, validA, doB, validB
  );

endinterface

// File: rtl/bram_out_pipe.sv
// Read-data register plus optional second output stage; holds data while no access is accepted.
module bram_out_pipe #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

  if (READ_LATENCY >= 2) begin : g_lat2
    logic [WIDTH-1:0] data2_q;
    logic             valid2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        valid2_q <= valid_q;
        if (valid_q) data2_q <= data_q;
      end
    end

    assign out_data  = data2_q;
    assign out_valid = valid2_q;
  end else begin : g_lat1
    assign out_data  = data_q;
    assign out_valid = valid_q;
  end

endmodule

// File: rtl/bram_tdp_asym_init.sv
// True dual-port RAM with asymmetric port widths, byte enables and a reset-time zero sweep.
// Optional BRAM_COLLISION_CHECK_EN adds a sticky overlap-with-write collision flag.
module bram_tdp_asym_init
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_A = 10,
  parameter int unsigned DATA_WIDTH_A = 64,
  parameter int unsigned ADDR_WIDTH_B = 9,
  parameter int unsigned DATA_WIDTH_B = 128,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned INIT_CLEAR   = 1
) (
  input  logic clk,
  input  logic rst,
  bram_tdp_asym_init_if.slave bus
`ifdef BRAM_COLLISION_CHECK_EN
  ,
  output logic collision
`endif
);

  localparam int unsigned NARROW      = min_val(DATA_WIDTH_A, DATA_WIDTH_B);
  localparam int unsigned RATIO       = max_val(DATA_WIDTH_A, DATA_WIDTH_B) / NARROW;
  localparam int unsigned LOG_RATIO   = log2(RATIO);
  localparam int unsigned RA          = DATA_WIDTH_A / NARROW;
  localparam int unsigned RB          = DATA_WIDTH_B / NARROW;
  localparam int unsigned LOG_RA      = log2(RA);
  localparam int unsigned LOG_RB      = log2(RB);
  localparam int unsigned ADDR_N      = max_val(ADDR_WIDTH_A, ADDR_WIDTH_B);
  localparam int unsigned ADDR_W      = min_val(ADDR_WIDTH_A, ADDR_WIDTH_B);
  localparam int unsigned DEPTH_N     = 1 << ADDR_N;
  localparam int unsigned LANES_N     = NARROW / BYTE_WIDTH;
  localparam bit          WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  if (DATA_WIDTH_A * (1 << ADDR_WIDTH_A) != DATA_WIDTH_B * (1 << ADDR_WIDTH_B)) begin : g_err_size
    $error("bram_tdp_asym_init: port A and B capacities differ");
  end
  if ((1 << LOG_RATIO) != RATIO) begin : g_err_ratio
    $error("bram_tdp_asym_init: width ratio is not a power of two");
  end
  if (NARROW % BYTE_WIDTH != 0) begin : g_err_byte
    $error("bram_tdp_asym_init: BYTE_WIDTH must divide the narrow width");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_err_lat
    $error("bram_tdp_asym_init: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_err_rdw
    $error("bram_tdp_asym_init: unsupported RDW_MODE");
  end

  logic [NARROW-1:0]       mem [DEPTH_N];
  init_state_e             state_q;
  logic [ADDR_W-1:0]       row_q;
  logic                    init_done_q;
  logic                    acc_a, acc_b;
  logic [ADDR_N-1:0]       base_a, base_b;
  logic [DATA_WIDTH_A-1:0] rd_a;
  logic [DATA_WIDTH_B-1:0] rd_b;

  assign bus.initDone = init_done_q;
  assign acc_a        = bus.enA & init_done_q;
  assign acc_b        = bus.enB & init_done_q;
  // First narrow word covered by each port's current address.
  assign base_a       = ADDR_N'(bus.addrA) << LOG_RA;
  assign base_b       = ADDR_N'(bus.addrB) << LOG_RB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (INIT_CLEAR != 0) ? CLEAR : READY;
      row_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          row_q <= row_q + 1'b1;
          if (row_q == '1) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end
        end
        READY: init_done_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int k = 0; k < int'(RATIO); k++) begin
        mem[(ADDR_N'(row_q) << LOG_RATIO) + ADDR_N'(k)] <= '0;
      end
    end else begin
      if (acc_a) begin
        for (int k = 0; k < int'(RA); k++) begin
          for (int j = 0; j < int'(LANES_N); j++) begin
            if (bus.weA[k*LANES_N + j]) begin
              mem[base_a + ADDR_N'(k)][j*BYTE_WIDTH +: BYTE_WIDTH] <=
                bus.diA[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
      // Port B is applied last so it wins when both ports write the same byte.
      if (acc_b) begin
        for (int k = 0; k < int'(RB); k++) begin
          for (int j = 0; j < int'(LANES_N); j++) begin
            if (bus.weB[k*LANES_N + j]) begin
              mem[base_b + ADDR_N'(k)][j*BYTE_WIDTH +: BYTE_WIDTH] <=
                bus.diB[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  // Reads see pre-edge contents; write-first overlays only this port's own written bytes.
  always_comb begin
    rd_a = '0;
    for (int k = 0; k < int'(RA); k++) begin
      for (int j = 0; j < int'(LANES_N); j++) begin
        rd_a[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH] =
          (WRITE_FIRST && bus.weA[k*LANES_N + j]) ?
          bus.diA[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH] :
          mem[base_a + ADDR_N'(k)][j*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_b = '0;
    for (int k = 0; k < int'(RB); k++) begin
      for (int j = 0; j < int'(LANES_N); j++) begin
        rd_b[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH] =
          (WRITE_FIRST && bus.weB[k*LANES_N + j]) ?
          bus.diB[(k*LANES_N + j)*BYTE_WIDTH +: BYTE_WIDTH] :
          mem[base_b + ADDR_N'(k)][j*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  bram_out_pipe #(
    .WIDTH       (DATA_WIDTH_A),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (rd_a),
    .in_valid (acc_a),
    .out_data (bus.doA),
    .out_valid(bus.validA)
  );

  bram_out_pipe #(
    .WIDTH       (DATA_WIDTH_B),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (rd_b),
    .in_valid (acc_b),
    .out_data (bus.doB),
    .out_valid(bus.validB)
  );

`ifdef BRAM_COLLISION_CHECK_EN
  logic overlap;
  logic collision_q;

  assign overlap = (base_a <= base_b + ADDR_N'(RB - 1)) && (base_b <= base_a + ADDR_N'(RA - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else if (acc_a && acc_b && overlap && ((|bus.weA) || (|bus.weB))) begin
      collision_q <= 1'b1;
      $error("bram_tdp_asym_init collision: addrA=%0h addrB=%0h", bus.addrA, bus.addrB);
    end
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_bram_tdp_asym_init.sv
// Directed bench: default RAM, read-first/latency-2 RAM and a small no-clear RAM in lockstep.
module tb_bram_tdp_asym_init;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bram_tdp_asym_init_if bus ();
  bram_tdp_asym_init_if bus2 ();
  bram_tdp_asym_init_if #(
    .ADDR_WIDTH_A(4), .DATA_WIDTH_A(16), .ADDR_WIDTH_B(3), .DATA_WIDTH_B(32)
  ) bus3 ();

`ifdef BRAM_COLLISION_CHECK_EN
  logic collision, collision2, collision3;
`endif

  bram_tdp_asym_init dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef BRAM_COLLISION_CHECK_EN
    , .collision(collision)
`endif
  );

  bram_tdp_asym_init #(.RDW_MODE(1), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef BRAM_COLLISION_CHECK_EN
    , .collision(collision2)
`endif
  );

  bram_tdp_asym_init #(
    .ADDR_WIDTH_A(4), .DATA_WIDTH_A(16), .ADDR_WIDTH_B(3), .DATA_WIDTH_B(32), .INIT_CLEAR(0)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
`ifdef BRAM_COLLISION_CHECK_EN
    , .collision(collision3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.enA  = 1'b0; bus.weA  = '0; bus.addrA  = '0; bus.diA  = '0;
    bus.enB  = 1'b0; bus.weB  = '0; bus.addrB  = '0; bus.diB  = '0;
    bus2.enA = 1'b0; bus2.weA = '0; bus2.addrA = '0; bus2.diA = '0;
    bus2.enB = 1'b0; bus2.weB = '0; bus2.addrB = '0; bus2.diB = '0;
    bus3.enA = 1'b0; bus3.weA = '0; bus3.addrA = '0; bus3.diA = '0;
    bus3.enB = 1'b0; bus3.weB = '0; bus3.addrB = '0; bus3.diB = '0;
  endtask

  initial begin
    int           cyc;
    int           bad;
    logic [127:0] p, q;
    p = 128'h00112233445566778899AABBCCDDEEFF;
    q = 128'hFEDCBA98765432100123456789ABCDEF;

    idle();
    rst = 1'b1;
    step();
    check("rst_initDone", bus.initDone, 0);
    check("rst_initDone3", bus3.initDone, 0);
    check("rst_doA", bus.doA, 0);
    check("rst_validA", bus.validA, 0);
    check("rst_validB", bus.validB, 0);
    rst = 1'b0;

    // Zero sweep: initDone low for exactly 512 cycles.
    cyc = 0;
    while (!bus.initDone && cyc < 600) begin
      step();
      cyc++;
      if (cyc == 1) check("noclear_initDone", bus3.initDone, 1);
    end
    check("clear_cycles", cyc, 512);
    check("clear_done2", bus2.initDone, 1);

    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      bus.enA   = 1'b1;
      bus.addrA = 10'(i);
      step();
      if (bus.doA !== 64'd0 || bus.validA !== 1'b1) bad++;
    end
    check("sweep_zero_valid", bad, 0);
    bus.enA = 1'b0;
    step();
    check("idle_validA", bus.validA, 0);

    // Width mapping and byte merge.
    bus.enB = 1'b1; bus.weB = '1; bus.addrB = 9'd5; bus.diB = p;
    step();
    check("wf_doB", bus.doB, p);
    check("validB", bus.validB, 1);
    bus.enB = 1'b0; bus.weB = '0;
    bus.enA = 1'b1; bus.addrA = 10'd10;
    step();
    check("a10_low", bus.doA, 64'h8899AABBCCDDEEFF);
    bus.addrA = 10'd11;
    step();
    check("a11_high", bus.doA, 64'h0011223344556677);
    bus.addrA = 10'd10; bus.weA = 8'h01; bus.diA = 64'hAA;
    step();
    check("wf_merge_doA", bus.doA, 64'h8899AABBCCDDEEAA);
    bus.enA = 1'b0; bus.weA = '0;
    bus.enB = 1'b1; bus.addrB = 9'd5;
    step();
    check("b5_byte0", bus.doB, 128'h00112233445566778899AABBCCDDEEAA);
    bus.enB = 1'b0;
    step();
    check("hold_doB", bus.doB, 128'h00112233445566778899AABBCCDDEEAA);
    check("idle_validB", bus.validB, 0);
`ifdef BRAM_COLLISION_CHECK_EN
    check("collision_clear", collision, 0);
`endif

    // A reads while B overwrites the same region: A gets the old contents.
    bus.enA = 1'b1; bus.addrA = 10'd10;
    bus.enB = 1'b1; bus.weB = '1; bus.addrB = 9'd5; bus.diB = q;
    step();
    check("rdw_other_old", bus.doA, 64'h8899AABBCCDDEEAA);
    bus.enB = 1'b0; bus.weB = '0;
    step();
    check("a10_new", bus.doA, 64'h0123456789ABCDEF);
`ifdef BRAM_COLLISION_CHECK_EN
    check("collision_set", collision, 1);
`endif

    // Both ports write overlapping bytes: B wins.
    bus.enA = 1'b1; bus.weA = '1; bus.addrA = 10'd8; bus.diA = 64'h1;
    bus.enB = 1'b1; bus.weB = '1; bus.addrB = 9'd4; bus.diB = '1;
    step();
    bus.weA = '0; bus.enB = 1'b0; bus.weB = '0;
    step();
    check("b_wins_a8", bus.doA, {64{1'b1}});
    bus.addrA = 10'd9;
    step();
    check("b_wins_a9", bus.doA, {64{1'b1}});

    // Independent, non-overlapping writes.
    bus.enA = 1'b1; bus.weA = '1; bus.addrA = 10'd100; bus.diA = 64'h5555AAAA5555AAAA;
    bus.enB = 1'b1; bus.weB = '1; bus.addrB = 9'd200; bus.diB = q;
    step();
    bus.weA = '0; bus.weB = '0; bus.addrA = 10'd401;
    step();
    check("indep_a401", bus.doA, 64'hFEDCBA9876543210);
    bus.addrA = 10'd100; bus.enB = 1'b0;
    step();
    check("indep_a100", bus.doA, 64'h5555AAAA5555AAAA);
    bus.enA = 1'b0;
`ifdef BRAM_COLLISION_CHECK_EN
    check("collision_sticky", collision, 1);
`endif

    // Write-first vs read-first with latency 2, identical stimulus on both RAMs.
    bus.enA  = 1'b1; bus.weA  = '1; bus.addrA  = 10'd3; bus.diA  = 64'h1234;
    bus2.enA = 1'b1; bus2.weA = '1; bus2.addrA = 10'd3; bus2.diA = 64'h1234;
    step();
    check("wf_new", bus.doA, 64'h1234);
    check("lat2_not_yet", bus2.validA, 0);
    bus.weA = '0; bus2.weA = '0;
    step();
    check("wf_reread", bus.doA, 64'h1234);
    check("lat2_first", bus2.doA, 64'h0);
    check("lat2_first_valid", bus2.validA, 1);
    bus.enA = 1'b0; bus2.enA = 1'b0;
    step();
    check("lat2_second", bus2.doA, 64'h1234);
    check("lat2_second_valid", bus2.validA, 1);
    step();
    check("lat2_idle", bus2.validA, 0);
    check("lat2_hold", bus2.doA, 64'h1234);

    // Small RAM without a clear sweep, narrow A / wide B.
    bus3.enB = 1'b1; bus3.weB = '1; bus3.addrB = 3'd2; bus3.diB = 32'hCAFEBABE;
    step();
    bus3.enB = 1'b0; bus3.weB = '0;
    bus3.enA = 1'b1; bus3.addrA = 4'd5;
    step();
    check("small_a5", bus3.doA, 16'hCAFE);
    bus3.addrA = 4'd4;
    step();
    check("small_a4", bus3.doA, 16'hBABE);
    bus3.enA = 1'b0;

    // Reset mid-sweep restarts the clear; user writes are ignored throughout.
    rst = 1'b1;
    step();
    check("rst2_doA", bus.doA, 0);
    check("rst2_initDone", bus.initDone, 0);
`ifdef BRAM_COLLISION_CHECK_EN
    check("collision_rst", collision, 0);
`endif
    rst = 1'b0;
    bus.enA = 1'b1; bus.weA = '1; bus.addrA = 10'd7; bus.diA = 64'hDEAD;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.validA !== 1'b0 || bus.initDone !== 1'b0) bad++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    while (!bus.initDone && cyc < 600) begin
      step();
      cyc++;
      if (bus.validA !== 1'b0) bad++;
    end
    check("restart_cycles", cyc, 512);
    check("sweep_no_access", bad, 0);
    bus.weA = '0;
    step();
    check("a7_cleared", bus.doA, 0);
    bus.addrA = 10'd8;
    step();
    check("a8_cleared", bus.doA, 0);
    check("a8_valid", bus.validA, 1);
    bus.enA = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
